// File: rtl/ir_pkg.sv
// NEC command codes, key count and sequencer state encoding shared across the IR path.
package ir_pkg;

  localparam int NUM_KEYS = 4;

  localparam logic [31:0] CODE_RIGHT = 32'h9D620707;
  localparam logic [31:0] CODE_UP    = 32'h9F600707;
  localparam logic [31:0] CODE_DOWN  = 32'h9E610707;
  localparam logic [31:0] CODE_LEFT  = 32'h9A650707;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } seq_state_t;

  function automatic logic [31:0] key_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return CODE_RIGHT;
      2'd1:    return CODE_UP;
      2'd2:    return CODE_DOWN;
      default: return CODE_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/ir_key_debounce.sv
// One key: 2-flop synchronizer then a stability counter; level follows key_in
// after 2 + DEBOUNCE_CYCLES cycles of a stable input, shorter glitches are dropped.
module ir_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk25,
  input  logic rst,
  input  logic key_in,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ir_key_sequencer.sv
// Debounced keys -> NEC command offers on valid/ready; valid rises 1 cycle after a key_state rise,
// cmd/valid hold under backpressure, and a held key re-offers REPEAT_CYCLES after each handshake.
module ir_key_sequencer
  import ir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 2700000
) (
  input  logic                clk25,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [31:0]         cmd,
  output logic                valid,
  input  logic                ready,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int SW = $clog2(NUM_KEYS);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RPT_MAX  = '1;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    ir_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk25 (clk25),
      .rst   (rst),
      .key_in(key[g]),
      .level (key_state[g])
    );
  end

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_nxt;
  logic [SW-1:0] low_idx;
  logic [31:0]   cmd_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;

  // Lowest-index pressed key wins simultaneous presses.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_state[i]) low_idx = SW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cmd_nxt   = cmd;
    rcnt_nxt  = rcnt;
    case (state)
      IDLE: begin
        if (key_state != '0) begin
          sel_nxt   = low_idx;
          cmd_nxt   = key_code(low_idx);
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (ready) begin
          rcnt_nxt  = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Release takes precedence over a repeat falling due in the same cycle.
        if (!key_state[sel]) begin
          state_nxt = IDLE;
        end else if (rcnt == RPT_LAST) begin
          state_nxt = SEND;
        end else if (rcnt != RPT_MAX) begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign valid = (state == SEND);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      cmd   <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cmd   <= cmd_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

endmodule

// File: tb/tb_ir_key_sequencer.sv
// Bench for ir_key_sequencer: directed scenarios with fixed expectations plus a
// randomized run against a time-based reference model.
`timescale 1ns/1ps
module tb_ir_key_sequencer;

  localparam int D = 4;
  localparam int R = 100;
  localparam logic [31:0] CODES [4] = '{32'h9D620707, 32'h9F600707, 32'h9E610707, 32'h9A650707};

  logic        clk25 = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic        ready;
  logic [31:0] cmd;
  logic        valid;
  logic [3:0]  key_state;

  int n_tests = 0;
  int n_fail  = 0;

  ir_key_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk25    (clk25),
    .rst      (rst),
    .key      (key),
    .cmd      (cmd),
    .valid    (valid),
    .ready    (ready),
    .key_state(key_state)
  );

  always #20 clk25 = ~clk25;

  // Reference model: a level flips once the last D synchronized samples all disagree
  // with it; frames are tracked by the cycle of their handshake rather than a counter.
  logic [3:0]  m_p0, m_p1, m_ks;
  logic [3:0]  m_hist [D];
  int          m_hn, m_sel, m_acc, m_cyc;
  logic        m_valid, m_hold;
  logic [31:0] m_cmd;

  always @(posedge clk25 or posedge rst) begin : model
    logic [3:0] seen, onehot, ks_new;
    logic [3:0] win [D];
    int         hn;
    bit         all_diff;
    if (rst) begin
      m_p0 <= '0; m_p1 <= '0; m_ks <= '0; m_hn <= 0;
      m_valid <= 1'b0; m_hold <= 1'b0; m_sel <= 0; m_acc <= 0; m_cyc <= 0; m_cmd <= '0;
      for (int i = 0; i < D; i++) m_hist[i] <= '0;
    end else begin
      if (m_valid) begin
        if (ready) begin
          m_valid <= 1'b0;
          m_hold  <= 1'b1;
          m_acc   <= m_cyc;
        end
      end else if (m_hold) begin
        if (!m_ks[m_sel]) m_hold <= 1'b0;
        else if (m_cyc - m_acc == R) m_valid <= 1'b1;
      end else if (m_ks != 4'd0) begin
        onehot  = m_ks & (~m_ks + 4'd1);
        m_sel   <= $clog2(onehot);
        m_cmd   <= CODES[$clog2(onehot)];
        m_valid <= 1'b1;
      end
      m_cyc <= m_cyc + 1;

      seen = m_p0;
      m_p0 <= m_p1;
      m_p1 <= key;
      win[0] = seen;
      for (int i = 1; i < D; i++) win[i] = m_hist[i-1];
      hn = (m_hn < D) ? m_hn + 1 : D;
      ks_new = m_ks;
      for (int k = 0; k < 4; k++) begin
        all_diff = (hn == D);
        for (int i = 0; i < D; i++) if (win[i][k] == m_ks[k]) all_diff = 1'b0;
        if (all_diff) ks_new[k] = ~m_ks[k];
      end
      for (int i = 0; i < D; i++) m_hist[i] <= win[i];
      m_hn <= hn;
      m_ks <= ks_new;
    end
  end

  task automatic test_reset();
    rst = 1'b1; key = 4'd0; ready = 1'b0;
    repeat (3) @(negedge clk25);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid); end
    n_tests++; if (cmd !== 32'd0) begin n_fail++; $display("FAIL reset_cmd got=%h want=0", cmd); end
    n_tests++; if (key_state !== 4'd0) begin n_fail++; $display("FAIL reset_key_state got=%b want=0", key_state); end
    rst = 1'b0;
    repeat (3) @(negedge clk25);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b want=0", valid); end
  endtask

  task automatic test_single_press();
    logic exp_v;
    @(negedge clk25);
    ready = 1'b1; key = 4'b0010;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk25);
      exp_v = (i == 2 + D + 1) || (i == 2 + D + 1 + R + 1);
      n_tests++;
      if (valid !== exp_v) begin n_fail++; $display("FAIL single_valid cyc=%0d got=%b want=%b", i, valid, exp_v); end
      if (exp_v) begin
        n_tests++;
        if (cmd !== CODES[1]) begin n_fail++; $display("FAIL single_cmd cyc=%0d got=%h want=%h", i, cmd, CODES[1]); end
      end
      if (i == 200) key = 4'd0;
    end
  endtask

  task automatic test_glitch();
    @(negedge clk25);
    key = 4'b0001;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk25);
      if (i == 3) key = 4'd0;
      n_tests++;
      if (key_state !== 4'd0 || valid !== 1'b0) begin
        n_fail++; $display("FAIL glitch cyc=%0d key_state=%b valid=%b want 0000/0", i, key_state, valid);
      end
    end
  endtask

  task automatic test_priority();
    int t;
    @(negedge clk25);
    ready = 1'b1; key = 4'b1100;
    t = 0;
    while (!valid && t < 20) begin @(negedge clk25); t++; end
    n_tests++; if (t != 2 + D + 1) begin n_fail++; $display("FAIL prio_latency got=%0d want=%0d", t, 2 + D + 1); end
    n_tests++; if (cmd !== CODES[2]) begin n_fail++; $display("FAIL prio_cmd got=%h want=%h", cmd, CODES[2]); end
    key = 4'b1000;
    @(negedge clk25);
    t = 1;
    while (!valid && t < 40) begin @(negedge clk25); t++; end
    n_tests++; if (t != 2 + D + 2) begin n_fail++; $display("FAIL prio_switch_latency got=%0d want=%0d", t, 2 + D + 2); end
    n_tests++; if (cmd !== CODES[3]) begin n_fail++; $display("FAIL prio_switch_cmd got=%h want=%h", cmd, CODES[3]); end
    key = 4'd0;
    repeat (20) @(negedge clk25);
  endtask

  task automatic test_backpressure();
    int t, xfers;
    @(negedge clk25);
    ready = 1'b0; key = 4'b0001;
    t = 0;
    while (!valid && t < 20) begin @(negedge clk25); t++; end
    n_tests++; if (t != 2 + D + 1) begin n_fail++; $display("FAIL bp_latency got=%0d want=%0d", t, 2 + D + 1); end
    key = 4'd0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk25);
      n_tests++;
      if (valid !== 1'b1 || cmd !== CODES[0]) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d valid=%b cmd=%h want 1/%h", i, valid, cmd, CODES[0]);
      end
    end
    ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 150; i++) begin
      if (valid && ready) xfers++;
      @(negedge clk25);
      if (i == 0) begin
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall got=%b want=0", valid); end
      end
    end
    n_tests++; if (xfers != 1) begin n_fail++; $display("FAIL bp_transfers got=%0d want=1", xfers); end
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk25);
    ready = 1'b0; key = 4'b0010;
    t = 0;
    while (!valid && t < 20) begin @(negedge clk25); t++; end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_offer got=%b want=1", valid); end
    #5 rst = 1'b1;
    #1;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", valid); end
    n_tests++; if (cmd !== 32'd0) begin n_fail++; $display("FAIL rstmid_cmd got=%h want=0", cmd); end
    n_tests++; if (key_state !== 4'd0) begin n_fail++; $display("FAIL rstmid_key_state got=%b want=0", key_state); end
    @(negedge clk25);
    @(negedge clk25);
    rst = 1'b0;
    t = 0;
    while (!valid && t < 20) begin @(negedge clk25); t++; end
    n_tests++; if (t != 2 + D + 1) begin n_fail++; $display("FAIL rstmid_relaunch got=%0d want=%0d", t, 2 + D + 1); end
    n_tests++; if (cmd !== CODES[1]) begin n_fail++; $display("FAIL rstmid_cmd2 got=%h want=%h", cmd, CODES[1]); end
    ready = 1'b1; key = 4'd0;
    repeat (20) @(negedge clk25);
  endtask

  task automatic test_release_boundary();
    int t;
    @(negedge clk25);
    ready = 1'b1; key = 4'b0100;
    t = 0;
    while (!valid && t < 20) begin @(negedge clk25); t++; end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rb_offer got=%b want=1", valid); end
    // Edge j=0 below is the handshake; key_state[2] falls on edge 99, when the repeat count is 99.
    for (int j = 0; j <= 220; j++) begin
      @(negedge clk25);
      if (j == 93) key = 4'd0;
      if (j == 98) begin
        n_tests++; if (key_state[2] !== 1'b1) begin n_fail++; $display("FAIL rb_level98 got=%b want=1", key_state[2]); end
      end
      if (j == 99) begin
        n_tests++; if (key_state[2] !== 1'b0) begin n_fail++; $display("FAIL rb_level99 got=%b want=0", key_state[2]); end
      end
      n_tests++;
      if (valid !== 1'b0) begin n_fail++; $display("FAIL rb_no_repeat j=%0d got=%b want=0", j, valid); end
    end
    key = 4'b0001;
    t = 0;
    while (!valid && t < 20) begin @(negedge clk25); t++; end
    n_tests++; if (t != 2 + D + 1) begin n_fail++; $display("FAIL rb_idle_relaunch got=%0d want=%0d", t, 2 + D + 1); end
    key = 4'd0;
    repeat (20) @(negedge clk25);
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 40; seg++) begin
      key = 4'($urandom_range(0, 15));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 250);
      repeat (len) begin
        ready = ($urandom_range(0, 9) < 7);
        @(negedge clk25);
        n_tests++;
        if (valid !== m_valid || cmd !== m_cmd || key_state !== m_ks) begin
          n_fail++;
          $display("FAIL random cyc=%0d valid=%b/%b cmd=%h/%h key_state=%b/%b (got/want)",
                   m_cyc, valid, m_valid, cmd, m_cmd, key_state, m_ks);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; key = 4'd0; ready = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_release_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
